// File: rtl/conv_layer_backward.sv
// rtl/conv_layer_backward.sv - conv layer backward pass: kernel gradient, input error, SGD kernel update
// One MAC per cycle; each result is written on the cycle of its last product.
module conv_layer_backward #(
  parameter int WIDTH            = 16,
  parameter int FRAC             = 8,
  parameter int NUM_KERNELS      = 2,
  parameter int KERNEL_DIM       = 3,
  parameter int INPUT_DIM_HEIGHT = 5,
  parameter int INPUT_DIM_WIDTH  = 5,
  parameter int LR_SHIFT         = 4,
  localparam int OUT_H = INPUT_DIM_HEIGHT - KERNEL_DIM + 1,
  localparam int OUT_W = INPUT_DIM_WIDTH - KERNEL_DIM + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] input_image    [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH],
  input  logic signed [WIDTH-1:0] output_error   [NUM_KERNELS][OUT_H][OUT_W],
  input  logic signed [WIDTH-1:0] input_kernels  [NUM_KERNELS][KERNEL_DIM][KERNEL_DIM],
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] input_error    [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH],
  output logic signed [WIDTH-1:0] kernel_grad    [NUM_KERNELS][KERNEL_DIM][KERNEL_DIM],
  output logic signed [WIDTH-1:0] output_kernels [NUM_KERNELS][KERNEL_DIM][KERNEL_DIM]
);
  localparam int PW         = 2 * WIDTH;
  localparam int GRAD_TERMS = OUT_H * OUT_W;
  localparam int IERR_TERMS = NUM_KERNELS * KERNEL_DIM * KERNEL_DIM;
  localparam int MAX_TERMS  = (GRAD_TERMS > IERR_TERMS) ? GRAD_TERMS : IERR_TERMS;
  localparam int ACC_W      = PW + $clog2(MAX_TERMS) + 1;
  localparam int NKW = (NUM_KERNELS > 1)      ? $clog2(NUM_KERNELS)      : 1;
  localparam int KDW = (KERNEL_DIM > 1)       ? $clog2(KERNEL_DIM)       : 1;
  localparam int OHW = (OUT_H > 1)            ? $clog2(OUT_H)            : 1;
  localparam int OWW = (OUT_W > 1)            ? $clog2(OUT_W)            : 1;
  localparam int IHW = (INPUT_DIM_HEIGHT > 1) ? $clog2(INPUT_DIM_HEIGHT) : 1;
  localparam int IWW = (INPUT_DIM_WIDTH > 1)  ? $clog2(INPUT_DIM_WIDTH)  : 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_GRAD, S_IERR, S_UPDATE, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic signed [WIDTH-1:0] r_img [INPUT_DIM_HEIGHT][INPUT_DIM_WIDTH];
  logic signed [WIDTH-1:0] r_err [NUM_KERNELS][OUT_H][OUT_W];
  logic signed [WIDTH-1:0] r_ker [NUM_KERNELS][KERNEL_DIM][KERNEL_DIM];
  logic signed [ACC_W-1:0] r_acc, w_sum;
  logic [NKW-1:0] r_k, w_k_nxt;
  logic [KDW-1:0] r_i, r_j, w_i_nxt, w_j_nxt;
  logic [OHW-1:0] r_y, w_ey;
  logic [OWW-1:0] r_x, w_ex;
  logic [IHW-1:0] r_r, w_gy, w_dy;
  logic [IWW-1:0] r_c, w_gx, w_dx;
  logic w_j_last, w_i_last, w_k_last, w_kij_last, w_x_last, w_y_last, w_c_last, w_r_last;
  logic w_dy_ok, w_dx_ok, w_grad_end, w_ierr_end;
  logic signed [PW-1:0] w_grad_prod, w_ierr_raw, w_ierr_prod, w_prod;

  function automatic logic signed [WIDTH-1:0] sat_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC;
    if (s > ACC_MAX) return ACC_MAX[WIDTH-1:0];
    if (s < ACC_MIN) return ACC_MIN[WIDTH-1:0];
    return s[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] sgd(input logic signed [WIDTH-1:0] k,
                                                  input logic signed [WIDTH-1:0] g);
    logic signed [WIDTH-1:0] step;
    logic signed [WIDTH:0]   d;
    step = g >>> LR_SHIFT;
    d = {k[WIDTH-1], k} - {step[WIDTH-1], step};
    if (d[WIDTH] != d[WIDTH-1])
      return d[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return d[WIDTH-1:0];
  endfunction

  assign w_j_last   = (r_j == KDW'(KERNEL_DIM - 1));
  assign w_i_last   = (r_i == KDW'(KERNEL_DIM - 1));
  assign w_k_last   = (r_k == NKW'(NUM_KERNELS - 1));
  assign w_kij_last = w_k_last && w_i_last && w_j_last;
  assign w_y_last   = (r_y == OHW'(OUT_H - 1));
  assign w_x_last   = (r_x == OWW'(OUT_W - 1));
  assign w_r_last   = (r_r == IHW'(INPUT_DIM_HEIGHT - 1));
  assign w_c_last   = (r_c == IWW'(INPUT_DIM_WIDTH - 1));
  assign w_grad_end = w_kij_last && w_y_last && w_x_last;
  assign w_ierr_end = w_kij_last && w_r_last && w_c_last;

  always_comb begin
    w_j_nxt = w_j_last ? '0 : r_j + KDW'(1);
    w_i_nxt = r_i;
    w_k_nxt = r_k;
    if (w_j_last) begin
      w_i_nxt = w_i_last ? '0 : r_i + KDW'(1);
      if (w_i_last) w_k_nxt = w_k_last ? '0 : r_k + NKW'(1);
    end
  end

  assign w_gy        = IHW'(r_y) + IHW'(r_i);
  assign w_gx        = IWW'(r_x) + IWW'(r_j);
  assign w_grad_prod = r_err[r_k][r_y][r_x] * r_img[w_gy][w_gx];

  // Out-of-window error taps read index 0 and are zeroed, keeping IERR latency fixed.
  assign w_dy        = r_r - IHW'(r_i);
  assign w_dx        = r_c - IWW'(r_j);
  assign w_dy_ok     = (r_r >= IHW'(r_i)) && ({1'b0, w_dy} < (IHW+1)'(OUT_H));
  assign w_dx_ok     = (r_c >= IWW'(r_j)) && ({1'b0, w_dx} < (IWW+1)'(OUT_W));
  assign w_ey        = w_dy_ok ? OHW'(w_dy) : '0;
  assign w_ex        = w_dx_ok ? OWW'(w_dx) : '0;
  assign w_ierr_raw  = r_err[r_k][w_ey][w_ex] * r_ker[r_k][r_i][r_j];
  assign w_ierr_prod = (w_dy_ok && w_dx_ok) ? w_ierr_raw : '0;
  assign w_prod      = (r_state == S_GRAD) ? w_grad_prod : w_ierr_prod;
  assign w_sum       = r_acc + ACC_W'(w_prod);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_GRAD;
      S_GRAD:   begin busy = 1'b1; if (w_grad_end) w_state_nxt = S_IERR; end
      S_IERR:   begin busy = 1'b1; if (w_ierr_end) w_state_nxt = S_UPDATE; end
      S_UPDATE: begin busy = 1'b1; if (w_kij_last) w_state_nxt = S_DONE; end
      S_DONE:   begin done = 1'b1; w_state_nxt = S_IDLE; end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_k <= '0; r_i <= '0; r_j <= '0; r_y <= '0; r_x <= '0; r_r <= '0; r_c <= '0;
      for (int r = 0; r < INPUT_DIM_HEIGHT; r++)
        for (int c = 0; c < INPUT_DIM_WIDTH; c++) begin
          r_img[r][c]       <= '0;
          input_error[r][c] <= '0;
        end
      for (int k = 0; k < NUM_KERNELS; k++) begin
        for (int y = 0; y < OUT_H; y++)
          for (int x = 0; x < OUT_W; x++) r_err[k][y][x] <= '0;
        for (int i = 0; i < KERNEL_DIM; i++)
          for (int j = 0; j < KERNEL_DIM; j++) begin
            r_ker[k][i][j]          <= '0;
            kernel_grad[k][i][j]    <= '0;
            output_kernels[k][i][j] <= '0;
          end
      end
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_img <= input_image;
          r_err <= output_error;
          r_ker <= input_kernels;
        end
        S_GRAD: begin
          if (w_y_last && w_x_last) begin
            kernel_grad[r_k][r_i][r_j] <= sat_shift(w_sum);
            r_acc <= '0;
            r_y   <= '0;
            r_x   <= '0;
            r_k <= w_k_nxt; r_i <= w_i_nxt; r_j <= w_j_nxt;
          end else begin
            r_acc <= w_sum;
            if (w_x_last) begin
              r_x <= '0;
              r_y <= r_y + OHW'(1);
            end else r_x <= r_x + OWW'(1);
          end
        end
        S_IERR: begin
          r_k <= w_k_nxt; r_i <= w_i_nxt; r_j <= w_j_nxt;
          if (w_kij_last) begin
            input_error[r_r][r_c] <= sat_shift(w_sum);
            r_acc <= '0;
            if (w_c_last) begin
              r_c <= '0;
              r_r <= w_r_last ? '0 : r_r + IHW'(1);
            end else r_c <= r_c + IWW'(1);
          end else r_acc <= w_sum;
        end
        S_UPDATE: begin
          output_kernels[r_k][r_i][r_j] <= sgd(r_ker[r_k][r_i][r_j], kernel_grad[r_k][r_i][r_j]);
          r_k <= w_k_nxt; r_i <= w_i_nxt; r_j <= w_j_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule
